pat_gen_seq_ctrl: RTL

//  Sequencer for the pattern-generator register bank. Accepts config writes of
//  NUM_REGS pattern words, then on a cfg_pat_gen_i rising edge streams words
//  0..len-1 over a valid/ready interface, repeating rep+1 passes. Drives

---
 rtl/pat_gen_pkg.sv | 15 +
 rtl/pat_reg_bank.sv | 37 +++
 rtl/pat_gen_seq_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pat_gen_pkg.sv
// Shared types and width helpers for the pattern-generator sequencer.
package pat_gen_pkg;

   typedef enum logic [1:0] {
      PG_IDLE = 2'd0,
      PG_RUN  = 2'd1,
      PG_DONE = 2'd2
   } pg_state_t;

   // Width able to hold any index 0..num_regs, including the length itself.
   function automatic int unsigned pg_idx_width(input int unsigned num_regs);
      return $clog2(num_regs + 1);
   endfunction

endpackage

// File: rtl/pat_reg_bank.sv
// Pattern word storage: one write port, one read mux with write-through so a
// word written on the start edge is the word streamed first.
module pat_reg_bank #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned NUM_REGS   = 21,
   parameter int unsigned IDX_W      = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic [IDX_W-1:0]      waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [IDX_W-1:0]      raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_c
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (we_i && (waddr_i == IDX_W'(i))) regs_q[i] <= wdata_i;
         end
      end
   end

   always_comb begin
      rdata_c = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (raddr_i == IDX_W'(i)) rdata_c = regs_q[i];
      end
      if (we_i && (waddr_i == raddr_i)) rdata_c = wdata_i;
   end

endmodule

// File: rtl/pat_gen_seq_ctrl.sv
// Pattern-generator sequencer: config writes into the word bank, then streams
// words 0..len-1 for rep+1 passes over valid/ready on a cfg_pat_gen_i rise.
module pat_gen_seq_ctrl
   import pat_gen_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH          = 32,
   parameter int unsigned DATA_WIDTH          = 12,
   parameter int unsigned NUM_REGS            = 21,
   parameter int unsigned SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
   parameter int unsigned REP_WIDTH           = 8,
   localparam int unsigned IDX_W              = pg_idx_width(NUM_REGS)
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           cfg_wr_i,
   input  logic [ADDR_WIDTH-1:0]          si_addr_i,
   input  logic [SUB_REGS_DATA_WIDTH-1:0] ctl_pat_data_i,
   input  logic [IDX_W-1:0]               cfg_len_i,
   input  logic [REP_WIDTH-1:0]           cfg_rep_i,
   input  logic                           cfg_pat_gen_i,
   input  logic                           pat_ready_i,
   output logic                           pat_valid_o,
   output logic [DATA_WIDTH-1:0]          pat_data_o,
   output logic [IDX_W-1:0]               pat_idx_o,
   output logic                           busy_o,
   output logic                           done_o,
   output logic                           err_o,
   output logic                           nopg_o
);

   pg_state_t             state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d, len_q, len_d;
   logic [IDX_W-1:0]      len_sat_c, rd_idx_c, waddr_c;
   logic [REP_WIDTH-1:0]  rep_q, rep_d;
   logic                  abort_q, abort_d, gen_q;
   logic [DATA_WIDTH-1:0] data_d, rd_data_c;
   logic                  wr_ok_c, last_c, unused_c;

   assign wr_ok_c   = cfg_wr_i && (si_addr_i < ADDR_WIDTH'(NUM_REGS)) && (state_q != PG_RUN);
   assign waddr_c   = IDX_W'(si_addr_i);
   assign len_sat_c = (cfg_len_i > IDX_W'(NUM_REGS)) ? IDX_W'(NUM_REGS) : cfg_len_i;
   assign last_c    = (idx_q == len_q - IDX_W'(1));
   assign unused_c  = ^ctl_pat_data_i;

   // Word to present next: successor within a pass, otherwise word 0 (start or wrap).
   assign rd_idx_c  = ((state_q == PG_RUN) && !last_c) ? idx_q + IDX_W'(1) : '0;

   pat_reg_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (IDX_W)
   ) u_bank (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (wr_ok_c),
      .waddr_i (waddr_c),
      .wdata_i (ctl_pat_data_i[DATA_WIDTH-1:0]),
      .raddr_i (rd_idx_c),
      .rdata_c (rd_data_c)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= PG_IDLE;
         idx_q       <= '0;
         len_q       <= '0;
         rep_q       <= '0;
         abort_q     <= 1'b0;
         gen_q       <= 1'b0;
         pat_valid_o <= 1'b0;
         pat_data_o  <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         nopg_o      <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         rep_q       <= rep_d;
         abort_q     <= abort_d;
         gen_q       <= cfg_pat_gen_i;
         pat_valid_o <= (state_d == PG_RUN);
         pat_data_o  <= data_d;
         busy_o      <= (state_d == PG_RUN);
         done_o      <= (state_d == PG_DONE);
         err_o       <= cfg_wr_i && !wr_ok_c;
         nopg_o      <= (state_d != PG_RUN);
      end
   end

   assign pat_idx_o = idx_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      rep_d   = rep_q;
      abort_d = abort_q;
      data_d  = pat_data_o;
      unique case (state_q)
         PG_IDLE: begin
            abort_d = 1'b0;
            if (cfg_pat_gen_i && !gen_q && (len_sat_c != '0)) begin
               state_d = PG_RUN;
               len_d   = len_sat_c;
               rep_d   = cfg_rep_i;
               idx_d   = '0;
               data_d  = rd_data_c;
            end
         end
         PG_RUN: begin
            if (!cfg_pat_gen_i) abort_d = 1'b1;
            if (pat_ready_i) begin
               // An abort is only honoured on a beat so valid never drops mid-handshake.
               if ((last_c && (rep_q == '0)) || abort_q || !cfg_pat_gen_i) begin
                  state_d = PG_DONE;
                  idx_d   = '0;
               end else if (last_c) begin
                  rep_d  = rep_q - REP_WIDTH'(1);
                  idx_d  = '0;
                  data_d = rd_data_c;
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  data_d = rd_data_c;
               end
            end
         end
         PG_DONE: state_d = PG_IDLE;
         default: state_d = PG_IDLE;
      endcase
   end

endmodule
